// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, opcode constants, opcode classes
// and the strobe bundle produced by the control sequencer.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_HALT = 4'd7
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        CLS_THREE   = 3'd0,
        CLS_TWO     = 3'd1,
        CLS_NOP     = 3'd2,
        CLS_HALT    = 3'd3,
        CLS_ILLEGAL = 3'd4
    } op_class_t;

    typedef struct packed {
        logic       pco;
        logic       pci;
        logic       incpc;
        logic       mari;
        logic       mdri;
        logic       read;
        logic       iri;
        logic       ryi;
        logic       zi;
        logic       zlowo;
        logic       mdro;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       rin;
        logic       rout;
        logic [4:0] alu_op;
        logic       run;
        logic       illegal;
    } strobes_t;

    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[31:27];
    endfunction

endpackage

// File: rtl/opcode_class.sv
// Purely combinational opcode classifier: maps a 5-bit opcode onto the
// execute-phase shape the sequencer must follow.
module opcode_class
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = CLS_THREE;
            OP_NEG, OP_NOT:                op_class = CLS_TWO;
            OP_NOP:                        op_class = CLS_NOP;
            OP_HALT:                       op_class = CLS_HALT;
            default:                       op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) then a class-dependent execute phase
// (T3-T5); all strobes are decoded combinationally from the registered state.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        stop,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic        pco,
    output logic        pci,
    output logic        incpc,
    output logic        mari,
    output logic        mdri,
    output logic        read,
    output logic        iri,
    output logic        ryi,
    output logic        zi,
    output logic        zlowo,
    output logic        mdro,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        rin,
    output logic        rout,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal
);

    state_t    state_reg, state_next;
    logic      illegal_reg, illegal_next;
    logic      stop_pending_reg, stop_pending_next;
    logic      halt_req;
    logic      in_program;
    logic [4:0] opcode;
    op_class_t op_class;
    strobes_t  strb;
    logic      unused_ir;

    assign opcode    = opcode_of(ir);
    assign unused_ir = ^ir[26:0];

    opcode_class u_opcode_class (
        .opcode   (opcode),
        .op_class (op_class)
    );

    // State register; the sticky illegal flag and a latched stop request ride along.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg        <= ST_IDLE;
            illegal_reg      <= 1'b0;
            stop_pending_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            illegal_reg      <= illegal_next;
            stop_pending_reg <= stop_pending_next;
        end
    end

    assign in_program = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
    assign halt_req   = stop | stop_pending_reg;

    always_comb begin
        state_next        = state_reg;
        illegal_next      = illegal_reg;
        stop_pending_next = stop_pending_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_T0;
            ST_T0:   state_next = ST_T1;
            ST_T1:   if (mem_ready) state_next = ST_T2;
            ST_T2:   state_next = ST_T3;
            ST_T3: begin
                case (op_class)
                    CLS_THREE, CLS_TWO: state_next = ST_T4;
                    CLS_NOP:            state_next = halt_req ? ST_HALT : ST_T0;
                    CLS_HALT:           state_next = ST_HALT;
                    default: begin
                        state_next   = ST_HALT;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            ST_T4: begin
                if (op_class == CLS_THREE) state_next = ST_T5;
                else                       state_next = halt_req ? ST_HALT : ST_T0;
            end
            ST_T5:   state_next = halt_req ? ST_HALT : ST_T0;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase

        // A stop seen anywhere in an instruction is held until its boundary.
        if (in_program) begin
            if (state_next == ST_T0 || state_next == ST_HALT) stop_pending_next = 1'b0;
            else if (stop)                                    stop_pending_next = 1'b1;
        end
    end

    always_comb begin
        strb = '0;
        case (state_reg)
            ST_T0: begin
                strb.pco   = 1'b1;
                strb.mari  = 1'b1;
                strb.incpc = 1'b1;
                strb.zi    = 1'b1;
            end
            ST_T1: begin
                strb.read = 1'b1;
                if (mem_ready) begin
                    strb.zlowo = 1'b1;
                    strb.pci   = 1'b1;
                    strb.mdri  = 1'b1;
                end
            end
            ST_T2: begin
                strb.mdro = 1'b1;
                strb.iri  = 1'b1;
            end
            ST_T3: begin
                case (op_class)
                    CLS_THREE: begin
                        strb.grb  = 1'b1;
                        strb.rout = 1'b1;
                        strb.ryi  = 1'b1;
                    end
                    CLS_TWO: begin
                        strb.grb    = 1'b1;
                        strb.rout   = 1'b1;
                        strb.zi     = 1'b1;
                        strb.alu_op = opcode;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (op_class)
                    CLS_THREE: begin
                        strb.grc    = 1'b1;
                        strb.rout   = 1'b1;
                        strb.zi     = 1'b1;
                        strb.alu_op = opcode;
                    end
                    CLS_TWO: begin
                        strb.zlowo = 1'b1;
                        strb.gra   = 1'b1;
                        strb.rin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                strb.zlowo = 1'b1;
                strb.gra   = 1'b1;
                strb.rin   = 1'b1;
            end
            default: ;
        endcase
        strb.run     = in_program;
        strb.illegal = illegal_reg | ((state_reg == ST_T3) && (op_class == CLS_ILLEGAL));
    end

    assign pco     = strb.pco;
    assign pci     = strb.pci;
    assign incpc   = strb.incpc;
    assign mari    = strb.mari;
    assign mdri    = strb.mdri;
    assign read    = strb.read;
    assign iri     = strb.iri;
    assign ryi     = strb.ryi;
    assign zi      = strb.zi;
    assign zlowo   = strb.zlowo;
    assign mdro    = strb.mdro;
    assign gra     = strb.gra;
    assign grb     = strb.grb;
    assign grc     = strb.grc;
    assign rin     = strb.rin;
    assign rout    = strb.rout;
    assign alu_op  = strb.alu_op;
    assign run     = strb.run;
    assign illegal = strb.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios followed by
// random instruction streams checked cycle by cycle against per-class strobe tables.
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic        start;
    logic        stop;
    logic        mem_ready;
    logic [31:0] ir;
    logic        pco, pci, incpc, mari, mdri, read, iri, ryi, zi, zlowo, mdro;
    logic        gra, grb, grc, rin, rout, run, illegal;
    logic [4:0]  alu_op;
    logic [17:0] obs;

    control_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .stop      (stop),
        .mem_ready (mem_ready),
        .ir        (ir),
        .pco       (pco),
        .pci       (pci),
        .incpc     (incpc),
        .mari      (mari),
        .mdri      (mdri),
        .read      (read),
        .iri       (iri),
        .ryi       (ryi),
        .zi        (zi),
        .zlowo     (zlowo),
        .mdro      (mdro),
        .gra       (gra),
        .grb       (grb),
        .grc       (grc),
        .rin       (rin),
        .rout      (rout),
        .alu_op    (alu_op),
        .run       (run),
        .illegal   (illegal)
    );

    assign obs = {pco, pci, incpc, mari, mdri, read, iri, ryi, zi, zlowo, mdro,
                  gra, grb, grc, rin, rout, run, illegal};

    localparam logic [17:0] M_PCO   = 18'h1 << 17;
    localparam logic [17:0] M_PCI   = 18'h1 << 16;
    localparam logic [17:0] M_INCPC = 18'h1 << 15;
    localparam logic [17:0] M_MARI  = 18'h1 << 14;
    localparam logic [17:0] M_MDRI  = 18'h1 << 13;
    localparam logic [17:0] M_READ  = 18'h1 << 12;
    localparam logic [17:0] M_IRI   = 18'h1 << 11;
    localparam logic [17:0] M_RYI   = 18'h1 << 10;
    localparam logic [17:0] M_ZI    = 18'h1 << 9;
    localparam logic [17:0] M_ZLOWO = 18'h1 << 8;
    localparam logic [17:0] M_MDRO  = 18'h1 << 7;
    localparam logic [17:0] M_GRA   = 18'h1 << 6;
    localparam logic [17:0] M_GRB   = 18'h1 << 5;
    localparam logic [17:0] M_GRC   = 18'h1 << 4;
    localparam logic [17:0] M_RIN   = 18'h1 << 3;
    localparam logic [17:0] M_ROUT  = 18'h1 << 2;
    localparam logic [17:0] M_RUN   = 18'h1 << 1;
    localparam logic [17:0] M_ILL   = 18'h1;

    int total;
    int bad;
    int icyc;
    int stop_at;
    int abort_at;
    bit aborted;
    bit ill_flag;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instruction class straight from the opcode table: 0 three-op, 1 two-op, 2 nop, 3 halt, 4 illegal.
    function automatic int cls_of(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return 0;
            5'b10001, 5'b10010:                     return 1;
            5'b11010:                               return 2;
            5'b11011:                               return 3;
            default:                                return 4;
        endcase
    endfunction

    // One clock cycle: outputs are compared at the falling edge, optionally followed by an async clear.
    task automatic cyc(input logic [17:0] e, input logic [4:0] ea, input bit ca, input string tag);
        if (aborted) return;
        stop = (icyc == stop_at);
        @(negedge clock);
        check(tag, 32'(obs), 32'(e));
        if (ca) check({tag, "_alu"}, 32'(alu_op), 32'(ea));
        if (icyc == abort_at) begin
            #2 clear = 1'b0;
            #1 check("async_clr", 32'({obs, alu_op}), 32'd0);
            aborted = 1'b1;
        end
        icyc++;
        @(posedge clock);
        #1;
        stop = 1'b0;
    endtask

    task automatic async_clear();
        @(negedge clock);
        #2 clear = 1'b0;
        #1 check("clr_now", 32'({obs, alu_op}), 32'd0);
        @(posedge clock);
        #1;
        check("clr_hold", 32'({obs, alu_op}), 32'd0);
        ill_flag = 1'b0;
        clear = 1'b1;
    endtask

    task automatic begin_session(input int idle_n);
        async_clear();
        stop_at  = -1;
        abort_at = -1;
        start    = 1'b0;
        for (int k = 0; k < idle_n; k++) begin
            mem_ready = 1'($urandom);
            cyc(18'h0, 5'd0, 1'b1, "idle");
        end
        start = 1'b1;
        cyc(18'h0, 5'd0, 1'b1, "idle_start");
        start = 1'b0;
    endtask

    task automatic halt_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            start     = 1'($urandom);
            mem_ready = 1'($urandom);
            cyc(ill_flag ? M_ILL : 18'h0, 5'd0, 1'b1, "halt");
        end
        start = 1'b0;
    endtask

    task automatic post_abort();
        aborted   = 1'b0;
        ill_flag  = 1'b0;
        start     = 1'b1;
        mem_ready = 1'b1;
        cyc(18'h0, 5'd0, 1'b1, "in_reset");
        clear = 1'b1;
        start = 1'b0;
        cyc(18'h0, 5'd0, 1'b1, "idle_after_clr");
        cyc(18'h0, 5'd0, 1'b1, "idle_after_clr");
    endtask

    task automatic run_instr(input logic [31:0] ir_val, input int waits, input int st_at,
                             input int ab_at, output bit halted);
        logic [4:0] op;
        int c;
        op       = ir_val[31:27];
        c        = cls_of(op);
        ir       = ir_val;
        stop_at  = st_at;
        abort_at = ab_at;
        icyc     = 0;
        mem_ready = 1'($urandom);
        cyc(M_PCO | M_MARI | M_INCPC | M_ZI | M_RUN, 5'd0, 1'b1, "t0");
        for (int w = 0; w < waits; w++) begin
            mem_ready = 1'b0;
            cyc(M_READ | M_RUN, 5'd0, 1'b1, "t1_wait");
        end
        mem_ready = 1'b1;
        cyc(M_READ | M_ZLOWO | M_PCI | M_MDRI | M_RUN, 5'd0, 1'b1, "t1_done");
        mem_ready = 1'($urandom);
        cyc(M_MDRO | M_IRI | M_RUN, 5'd0, 1'b1, "t2");
        mem_ready = 1'($urandom);
        case (c)
            0: begin
                cyc(M_GRB | M_ROUT | M_RYI | M_RUN, 5'd0, 1'b0, "x3_t3");
                cyc(M_GRC | M_ROUT | M_ZI | M_RUN, op, 1'b1, "x3_t4");
                cyc(M_ZLOWO | M_GRA | M_RIN | M_RUN, 5'd0, 1'b0, "x3_t5");
            end
            1: begin
                cyc(M_GRB | M_ROUT | M_ZI | M_RUN, op, 1'b1, "x2_t3");
                cyc(M_ZLOWO | M_GRA | M_RIN | M_RUN, 5'd0, 1'b0, "x2_t4");
            end
            4:       cyc(M_RUN | M_ILL, 5'd0, 1'b0, "ill_t3");
            default: cyc(M_RUN, 5'd0, 1'b0, "x1_t3");
        endcase
        halted   = (c >= 3) || (st_at >= 0);
        ill_flag = (c == 4);
        $display("instr ir=%h op=%b waits=%0d stop_at=%0d abort_at=%0d halted=%0d aborted=%0d",
                 ir_val, op, waits, st_at, ab_at, halted, aborted);
        stop_at  = -1;
        abort_at = -1;
    endtask

    initial begin
        logic [4:0]  legal_ops [8];
        logic [31:0] rv;
        bit h;
        int n, waits, ncyc, len, st, ab;

        legal_ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                      5'b10001, 5'b10010, 5'b11010, 5'b11011};
        total = 0; bad = 0; icyc = 0; stop_at = -1; abort_at = -1;
        aborted = 1'b0; ill_flag = 1'b0;
        clear = 1'b0; start = 1'b0; stop = 1'b0; mem_ready = 1'b0; ir = 32'h0;
        @(posedge clock);
        #1;

        // neg, add with delayed memory, nop, then not with a stop pulse during its fetch
        begin_session(0);
        run_instr({5'b10001, 4'b0010, 4'b0000, 19'b0}, 0, -1, -1, h);
        run_instr({5'b00011, 4'b0011, 4'b0001, 4'b0010, 15'b0}, 3, -1, -1, h);
        run_instr({5'b11010, 27'h0}, 1, -1, -1, h);
        run_instr({5'b10010, 27'h0}, 0, 1, -1, h);
        halt_cycles(3);

        begin_session(1);
        run_instr({5'b11011, 27'h0}, 0, -1, -1, h);
        halt_cycles(20);

        begin_session(0);
        run_instr({5'b11111, 27'h0}, 2, -1, -1, h);
        halt_cycles(3);

        begin_session(0);
        run_instr({5'b10001, 4'b0010, 4'b0000, 19'b0}, 0, -1, 4, h);
        post_abort();

        begin_session(2);
        run_instr({5'b00100, 27'h123}, 5, -1, 3, h);
        post_abort();

        for (int s = 0; s < 40; s++) begin
            begin_session(int'($urandom_range(0, 2)));
            n = int'($urandom_range(1, 6));
            h = 1'b0;
            for (int i = 0; i < n && !h && !aborted; i++) begin
                rv = {($urandom_range(0, 4) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 7)],
                      27'($urandom)};
                case (cls_of(rv[31:27]))
                    0:       len = 3;
                    1:       len = 2;
                    default: len = 1;
                endcase
                waits = int'($urandom_range(0, 3));
                ncyc  = 3 + waits + len;
                st    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, ncyc - 1)) : -1;
                ab    = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, ncyc - 1)) : -1;
                run_instr(rv, waits, st, ab, h);
            end
            if (aborted) post_abort();
            else if (h)  halt_cycles(4);
        end

        async_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
